// File: rtl/axi_pkg.sv
// Shared AXI4 types and decode helpers for the burst RAM responder.
package axi_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [7:0]  len_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam int         STRB_W  = 4;

  // A burst is rejected as a whole when its start address, size or type is unsupported.
  function automatic logic burst_bad(addr_t addr, logic [2:0] size, logic [1:0] burst,
                                     int unsigned idx_w);
    return ((addr >> idx_w) != '0) || (size != SIZE_4B) ||
           (burst != FIXED && burst != INCR);
  endfunction

endpackage

// File: rtl/axi_ram_2p.sv
// One write port, one read port RAM with byte enables and a registered read.
// A same-address read and write in one cycle returns the old word.
module axi_ram_2p
  import axi_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  strb_t         wstrb,
  input  data_t         wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output data_t         rdata
);

  logic [STRB_W-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[waddr][b] <= wdata[8*b +: 8];
      end
    end
  end

  // rdata only moves when re is set, so the read FSM can hold a beat by withholding re.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave backed by a word-indexed RAM; independent INCR/FIXED read and write engines.
module axi_burst_ram
  import axi_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int            IW      = $clog2(DEPTH);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  wstate_t       w_state, w_nxt;
  logic [IW-1:0] w_idx;
  len_t          w_cnt, w_len;
  logic          w_fixed, w_err;
  resp_t         w_bresp;

  rstate_t       r_state, r_nxt;
  logic [IW-1:0] r_idx, r_idx_next;
  len_t          r_cnt, r_len;
  logic          r_fixed, r_err;

  logic          ram_we, ram_re;
  logic [IW-1:0] ram_raddr;
  data_t         ram_q;

  axi_ram_2p #(.DEPTH(DEPTH), .IW(IW)) u_ram (
    .clk   (aclk),
    .we    (ram_we),
    .waddr (w_idx),
    .wstrb (wstrb),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // ---------------- write engine ----------------
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) w_state <= W_IDLE;
    else           w_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    ram_we  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_we = !w_err;
          if (w_cnt == w_len) w_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_nxt = W_IDLE;
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_idx   <= '0;
      w_cnt   <= '0;
      w_len   <= '0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
      w_bresp <= OKAY;
    end else if (w_state == W_IDLE && awvalid) begin
      w_idx   <= awaddr[IW-1:0];
      w_cnt   <= '0;
      w_len   <= awlen;
      w_fixed <= (awburst == FIXED);
      w_err   <= burst_bad(awaddr, awsize, awburst, IW);
      w_bresp <= burst_bad(awaddr, awsize, awburst, IW) ? SLVERR : OKAY;
    end else if (w_state == W_DATA && wvalid) begin
      w_cnt <= w_cnt + 8'd1;
      if (!w_fixed) w_idx <= w_idx + IDX_ONE;
      // Misplaced wlast only taints the response; the beat count still follows awlen.
      if (wlast != (w_cnt == w_len)) w_bresp <= SLVERR;
    end
  end

  assign bresp = w_bresp;

  // ---------------- read engine ----------------
  assign r_idx_next = r_fixed ? r_idx : r_idx + IDX_ONE;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state <= R_IDLE;
    else           r_state <= r_nxt;
  end

  always_comb begin
    r_nxt     = r_state;
    arready   = 1'b0;
    rvalid    = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = r_idx;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          if (RD_LAT == 2) begin
            r_nxt = R_WAIT;
          end else begin
            r_nxt     = R_DATA;
            ram_re    = 1'b1;
            ram_raddr = araddr[IW-1:0];
          end
        end
      end
      R_WAIT: begin
        ram_re = 1'b1;
        r_nxt  = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) begin
          // Prefetch the next word so an unstalled burst moves one beat per cycle.
          ram_raddr = r_idx_next;
          ram_re    = (r_cnt != r_len);
          if (r_cnt == r_len) r_nxt = R_IDLE;
        end
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_fixed <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == R_IDLE && arvalid) begin
      r_idx   <= araddr[IW-1:0];
      r_cnt   <= '0;
      r_len   <= arlen;
      r_fixed <= (arburst == FIXED);
      r_err   <= burst_bad(araddr, arsize, arburst, IW);
    end else if (r_state == R_DATA && rready) begin
      r_cnt <= r_cnt + 8'd1;
      r_idx <= r_idx_next;
    end
  end

  assign rlast = (r_state == R_DATA) && (r_cnt == r_len);
  assign rresp = (r_state == R_DATA && r_err) ? SLVERR : OKAY;
  assign rdata = (r_state == R_DATA && !r_err) ? ram_q : '0;

endmodule

// File: tb/tb_axi_burst_ram.sv
// Table-driven bench for axi_burst_ram with a read-beat scoreboard and a memory model.
module tb_axi_burst_ram;
  import axi_pkg::*;

  localparam int DEPTH = 256;

  logic        aclk = 1'b0, areset_n = 1'b0;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  axi_burst_ram #(.DEPTH(DEPTH), .RD_LAT(1)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] base;
    bit          bad_last;
    bit          stall;
    logic [1:0]  resp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  vec_t        vq[$];
  beat_t       sbq[$];
  logic [31:0] mdl [DEPTH];
  int          errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic bit dec_err(logic [31:0] a, logic [2:0] s, logic [1:0] b);
    return ((a >> 8) != 0) || (s != 3'd2) || (b > 2'd1);
  endfunction

  task automatic write_burst(input vec_t v);
    bit got;
    int t;
    logic [7:0] idx;
    awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst; awvalid = 1'b1;
    t = 0;
    do begin @(negedge aclk); got = awready; @(posedge aclk); #1; t++; end
    while (!got && t < 50);
    if (!got) check("aw_timeout", 32'(got), 32'd1);
    awvalid = 1'b0;
    idx = v.addr[7:0];
    for (int b = 0; b <= int'(v.len); b++) begin
      wdata = v.base + 32'(b); wstrb = v.strb;
      wlast = v.bad_last ? (b == 0) : (b == int'(v.len));
      wvalid = 1'b1;
      t = 0;
      do begin @(negedge aclk); got = wready; @(posedge aclk); #1; t++; end
      while (!got && t < 50);
      if (!got) check("w_timeout", 32'(got), 32'd1);
      if (!dec_err(v.addr, v.size, v.burst))
        for (int k = 0; k < 4; k++) if (v.strb[k]) mdl[idx][8*k +: 8] = wdata[8*k +: 8];
      if (v.burst == 2'd1) idx++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    @(negedge aclk);
    check("bvalid_lat", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'(v.resp));
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk);
    check("awready_ret", 32'(awready), 32'd1);
    @(posedge aclk); #1;
  endtask

  task automatic read_burst(input vec_t v);
    bit got, first, stalled;
    int t, n, cyc;
    logic [7:0] idx;
    logic [31:0] held;
    beat_t e;
    idx = v.addr[7:0];
    for (int b = 0; b <= int'(v.len); b++) begin
      e.data = dec_err(v.addr, v.size, v.burst) ? 32'd0 : mdl[idx];
      e.resp = v.resp;
      e.last = (b == int'(v.len));
      sbq.push_back(e);
      if (v.burst == 2'd1) idx++;
    end
    araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst; arvalid = 1'b1;
    t = 0;
    do begin @(negedge aclk); got = arready; @(posedge aclk); #1; t++; end
    while (!got && t < 50);
    if (!got) check("ar_timeout", 32'(got), 32'd1);
    arvalid = 1'b0;
    n = 0; cyc = 0; first = 1'b1; stalled = 1'b0; held = '0;
    while (n <= int'(v.len) && cyc < 200) begin
      rready = v.stall ? (cyc % 3 == 0) : 1'b1;
      @(negedge aclk);
      if (first) begin check("rlat", 32'(rvalid), 32'd1); first = 1'b0; end
      if (stalled) begin check("r_hold", rdata, held); stalled = 1'b0; end
      if (rvalid && rready) begin
        if (sbq.size() == 0) check("r_extra", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", 32'(rresp), 32'(e.resp));
          check("rlast", 32'(rlast), 32'(e.last));
        end
        n++;
      end else if (rvalid) begin
        held = rdata; stalled = 1'b1;
      end
      @(posedge aclk); #1; cyc++;
    end
    rready = 1'b0;
    if (n <= int'(v.len)) check("r_timeout", 32'(n), 32'(v.len) + 32'd1);
    @(negedge aclk);
    check("r_done_rvalid", 32'(rvalid), 32'd0);
    check("r_done_arready", 32'(arready), 32'd1);
    @(posedge aclk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    //              wr     addr        len    burst size   strb   base          badl  stall resp
    vq.push_back('{1'b1, 32'h004, 8'd3, INCR,  3'd2, 4'hF, 32'hdeadbeef, 1'b0, 1'b0, OKAY});
    vq.push_back('{1'b0, 32'h004, 8'd3, INCR,  3'd2, 4'hF, 32'h0,        1'b0, 1'b0, OKAY});
    vq.push_back('{1'b0, 32'h004, 8'd3, INCR,  3'd2, 4'hF, 32'h0,        1'b0, 1'b1, OKAY});
    vq.push_back('{1'b1, 32'h008, 8'd0, INCR,  3'd2, 4'hF, 32'h11223344, 1'b0, 1'b0, OKAY});
    vq.push_back('{1'b1, 32'h008, 8'd0, INCR,  3'd2, 4'h3, 32'haabbccdd, 1'b0, 1'b0, OKAY});
    vq.push_back('{1'b0, 32'h008, 8'd0, INCR,  3'd2, 4'hF, 32'h0,        1'b0, 1'b0, OKAY});
    vq.push_back('{1'b1, 32'h404, 8'd0, INCR,  3'd2, 4'hF, 32'h55555555, 1'b0, 1'b0, SLVERR});
    vq.push_back('{1'b0, 32'h004, 8'd0, INCR,  3'd2, 4'hF, 32'h0,        1'b0, 1'b0, OKAY});
    vq.push_back('{1'b0, 32'h000, 8'd1, WRAP,  3'd2, 4'hF, 32'h0,        1'b0, 1'b0, SLVERR});
    vq.push_back('{1'b1, 32'h010, 8'd2, FIXED, 3'd2, 4'hF, 32'h00000100, 1'b0, 1'b0, OKAY});
    vq.push_back('{1'b0, 32'h010, 8'd2, FIXED, 3'd2, 4'hF, 32'h0,        1'b0, 1'b0, OKAY});
    vq.push_back('{1'b1, 32'h0FE, 8'd3, INCR,  3'd2, 4'hF, 32'h00000200, 1'b0, 1'b0, OKAY});
    vq.push_back('{1'b0, 32'h0FE, 8'd3, INCR,  3'd2, 4'hF, 32'h0,        1'b0, 1'b1, OKAY});
    vq.push_back('{1'b0, 32'h014, 8'd0, INCR,  3'd1, 4'hF, 32'h0,        1'b0, 1'b0, SLVERR});
    vq.push_back('{1'b1, 32'h020, 8'd0, INCR,  3'd3, 4'hF, 32'h66666666, 1'b0, 1'b0, SLVERR});
    vq.push_back('{1'b1, 32'h030, 8'd2, INCR,  3'd2, 4'hF, 32'h77777777, 1'b1, 1'b0, SLVERR});

    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_rdata",   rdata,        32'd0);
    @(negedge aclk); areset_n = 1'b1;
    @(posedge aclk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].wr) write_burst(vq[i]);
      else          read_burst(vq[i]);
    end
    check("sb_empty", 32'(sbq.size()), 32'd0);

    // Reset while beat 2 of a 4-beat read is on the bus.
    araddr = 32'h4; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    @(negedge aclk);
    check("mr_arready", 32'(arready), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge aclk);
    check("mr_beat1", rdata, 32'hdeadbeef);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("mr_beat2", rdata, 32'hdeadbef0);
    areset_n = 1'b0;
    #1;
    check("mr_rvalid", 32'(rvalid), 32'd0);
    check("mr_arready_rst", 32'(arready), 32'd1);
    @(posedge aclk); #1;
    rready = 1'b0;
    @(negedge aclk); areset_n = 1'b1;
    #1;
    check("mr_rvalid_after", 32'(rvalid), 32'd0);
    check("mr_arready_after", 32'(arready), 32'd1);
    @(posedge aclk); #1;
    read_burst(vq[1]);
    check("sb_empty_end", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_burst_ram.md
Name: axi_burst_ram

Overview:
- AXI4 memory-mapped responder (slave end) backed by a word-indexed RAM.
- Accepts INCR/FIXED bursts on AW/W/B and AR/R; independent read and write engines.
- Sits on the slave side of axi_if; the drop-in target for axi_master in block- and system-level benches.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, ≥ 16.
- RD_LAT, 1, cycles from AR handshake to first rvalid; legal values 1 or 2.

Ports:
- aclk  in  1  clock
- areset_n  in  1  async active-low reset
- awaddr/awlen/awsize/awburst/awvalid/awready  in×5 / out  32/8/3/2/1/1  write address channel
- wdata/wstrb/wlast/wvalid/wready  in×4 / out  32/4/1/1/1  write data channel
- bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- araddr/arlen/arsize/arburst/arvalid/arready  in×5 / out  32/8/3/2/1/1  read address channel
- rdata/rresp/rlast/rvalid/rready  out×4 / in  32/2/1/1/1  read data channel

Behaviour:
- Clock is aclk; reset is areset_n: one clock, reset asynchronous and active-low.
- Reset values:
  - awready=1, arready=1; wready, bvalid, rvalid, rlast = 0.
  - bresp = rresp = OKAY; rdata = 0.
  - Both FSMs return to IDLE. RAM contents are not reset.
- Addressing:
  - Word index = addr[$clog2(DEPTH)-1:0]; +1 per beat for INCR, constant for FIXED.
  - Index wraps modulo DEPTH.
  - Any set addr bit above the index field → whole burst is SLVERR.
  - awsize/arsize ≠ 3'b010 → SLVERR.
  - WRAP burst → SLVERR.
  - An SLVERR burst never modifies RAM; its reads return rdata=0.
- Write FSM: W_IDLE → W_DATA → W_RESP.
  - W_IDLE: awready=1; on awvalid capture addr/len/burst, drop awready, go W_DATA.
  - W_DATA: wready=1; each wvalid&wready beat writes bytes enabled by wstrb, then advances the index.
    - Beat count reaching awlen+1 → go W_RESP.
    - wlast asserted on the wrong beat → bresp=SLVERR, but beats are still counted to awlen+1.
  - W_RESP: bvalid=1 held until bready; then go W_IDLE with awready=1 on the following cycle.
  - bresp reflects the worst error seen in the burst.
- Read FSM: R_IDLE → R_WAIT (only when RD_LAT=2) → R_DATA.
  - R_IDLE: arready=1; capture on handshake, drop arready.
  - RAM read is registered; first rvalid appears RD_LAT cycles after the AR handshake.
  - R_DATA: rdata/rresp/rlast stay stable while rvalid&!rready; the next word is prefetched so back-to-back beats sustain one beat per cycle.
  - rlast=1 on beat arlen+1. After that handshake go R_IDLE; arready returns next cycle.
- Same word read and written in the same cycle: the read returns old data (read-before-write).
- Read and write engines run concurrently; no ordering between channels.
- Reset mid-burst: all in-flight state is discarded immediately. Partially written beats remain in RAM.
- A W beat arriving before its AW is held off (wready=0 outside W_DATA).

Decomposition:
- axi_pkg holds:
  - addr_t, data_t, strb_t, len_t types.
  - resp_t enum (OKAY, EXOKAY, SLVERR, DECERR).
  - burst_t enum (FIXED, INCR, WRAP).
  - SIZE_4B constant.
- One sub-module, axi_ram_2p: 1W/1R port, byte-enabled, registered read.
- Both FSMs live in axi_burst_ram.

Test Plan:
- INCR write: awaddr=4, awlen=3, wdata=deadbeef..deadbef2, wstrb=F → RAM[4..7] match; bresp=OKAY; bvalid one cycle after the 4th beat.
- INCR read of the same region with rready tied 1 → four consecutive rvalid beats deadbeef..deadbef2; rlast only on beat 4; rresp=OKAY.
- Read with rready toggling 1,0,0,1,... → rdata held stable during stalls, no beats lost or duplicated.
- Write wstrb=4'b0011 to word 8 (prior contents 11223344) with wdata=aabbccdd → RAM[8]=1122ccdd.
- Error cases:
  - awaddr beyond DEPTH → bresp=SLVERR, RAM unchanged.
  - arburst=WRAP, arlen=1 → two beats, rresp=SLVERR, rdata=0.
- Reset pulse during beat 2 of a 4-beat read → rvalid=0 and arready=1 right after reset; a new read then completes normally.
